// File: rtl/package_chk.sv
// Read-side package checker: issues one BURST_BEATS read per trigger and checks the
// returned beats against a continuous incrementing 64-bit pattern.
// Optional idle-beat watchdog compiled in with `define PKG_RD_TIMEOUT_EN.
module package_chk #(
  parameter int BURST_BEATS = 1024,
  parameter int ADDR_STEP   = 8192,
  parameter int TMO_CYCLES  = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        user_rd_trig,
  output logic [44:0] user_rd_cmd,
  output logic        user_cmd_ren,
  input  logic [63:0] user_rd_data,
  input  logic        user_rd_valid,
  output logic        rd_done,
  output logic        err_flag,
  output logic [15:0] err_cnt,
  output logic        rd_timeout
);

  localparam int              CW   = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [CW-1:0]   LAST = CW'(BURST_BEATS - 1);
  localparam logic [12:0]     LEN  = 13'(BURST_BEATS);
  localparam logic [31:0]     STEP = 32'(ADDR_STEP);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_WAIT = 4'b0100,
    S_END  = 4'b1000
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   addr;
  logic [63:0]   exp_data;
  logic [CW-1:0] beat_cnt;
  logic          accept, last_beat, mismatch, tmo_hit;

  assign accept    = (state == S_WAIT) && user_rd_valid;
  assign last_beat = accept && (beat_cnt == LAST);
  assign mismatch  = accept && (user_rd_data != exp_data);

`ifdef PKG_RD_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] wd_cnt;

  // Fires on the TMO_CYCLES-th consecutive WAIT cycle without an accepted beat.
  assign tmo_hit = (state == S_WAIT) && !accept && (wd_cnt == TW'(TMO_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt     <= '0;
      rd_timeout <= 1'b0;
    end else begin
      if ((state == S_WAIT) && !accept && !tmo_hit) wd_cnt <= wd_cnt + TW'(1);
      else                                          wd_cnt <= '0;
      if (tmo_hit) rd_timeout <= 1'b1;
    end
  end
`else
  assign tmo_hit    = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (user_rd_trig) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  if (last_beat || tmo_hit) state_nxt = S_END;
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address advances once the command has gone out, so package N reads N*ADDR_STEP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr     <= '0;
      exp_data <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == S_REQ) addr <= addr + STEP;
      if (accept) exp_data <= exp_data + 64'd1;
      if (last_beat || tmo_hit) beat_cnt <= '0;
      else if (accept)          beat_cnt <= beat_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else if (mismatch) begin
      err_flag <= 1'b1;
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign user_cmd_ren = (state == S_REQ);
  assign user_rd_cmd  = user_cmd_ren ? {LEN, addr} : '0;
  assign rd_done      = (state == S_END);

endmodule
